// File: rtl/alu_issue_ctrl_if.sv
// Handshake and datapath bundle between the issue stage, the register file,
// the ALU and write-back for alu_issue_ctrl.
//   slave  : view taken by alu_issue_ctrl
//   master : view taken by the surrounding pipeline / environment
interface alu_issue_ctrl_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;
    localparam int unsigned RA_W = 5;

    logic            Instr_Valid_i;
    logic [XLEN-1:0] Instruction_i;
    logic            Instr_Ready_o;
    logic [XLEN-1:0] Rs1_Data_i;
    logic [XLEN-1:0] Rs2_Data_i;
    logic [OP_W-1:0] ALU_Operation_o;
    logic [XLEN-1:0] A_o;
    logic [XLEN-1:0] B_o;
    logic [XLEN-1:0] ALU_Result_i;
    logic            Zero_i;
    logic            Rd_Write_o;
    logic [RA_W-1:0] Rd_Addr_o;
    logic [XLEN-1:0] Rd_Data_o;
    logic            Zero_o;
    logic            Illegal_o;

    modport slave (
        input  Instr_Valid_i, Instruction_i, Rs1_Data_i, Rs2_Data_i,
               ALU_Result_i, Zero_i,
        output Instr_Ready_o, ALU_Operation_o, A_o, B_o,
               Rd_Write_o, Rd_Addr_o, Rd_Data_o, Zero_o, Illegal_o
    );

    modport master (
        output Instr_Valid_i, Instruction_i, Rs1_Data_i, Rs2_Data_i,
               ALU_Result_i, Zero_i,
        input  Instr_Ready_o, ALU_Operation_o, A_o, B_o,
               Rd_Write_o, Rd_Addr_o, Rd_Data_o, Zero_o, Illegal_o
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller for a small RV32I ALU subset (LUI, ADDI, ORI,
// SLLI, SRLI, SUB). Accepts one instruction at a time, decodes it into ALU
// operands, holds them for EXEC_WAIT cycles, captures the ALU result and
// issues a one-cycle register write-back. Unsupported encodings raise a
// one-cycle Illegal_o pulse instead.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : instruction handshake, operand read data, ALU drive/return,
//           write-back and illegal-instruction outputs (all registered)
module alu_issue_ctrl #(
    parameter int unsigned EXEC_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.slave   bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(EXEC_WAIT - 1);

    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_REG = 7'b0110011;

    localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SRL = 4'b0011;
    localparam logic [OP_W-1:0] ALU_LUI = 4'b1000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b1001;
    localparam logic [OP_W-1:0] ALU_SLL = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_e;

    state_e          state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic            ready_q,   ready_d;
    logic [OP_W-1:0] op_q,      op_d;
    logic [XLEN-1:0] a_q,       a_d;
    logic [XLEN-1:0] b_q,       b_d;
    logic            rd_wr_q,   rd_wr_d;
    logic [RA_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            zero_q,    zero_d;
    logic            illegal_q, illegal_d;

    logic            dec_legal_c;
    logic [OP_W-1:0] dec_op_c;
    logic [XLEN-1:0] dec_a_c;
    logic [XLEN-1:0] dec_b_c;

    // Decode of the offered instruction; only consumed on an accept edge.
    always_comb begin
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        instr  = bus.Instruction_i;
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];

        dec_legal_c = 1'b0;
        dec_op_c    = ALU_ADD;
        dec_a_c     = bus.Rs1_Data_i;
        dec_b_c     = {{20{instr[31]}}, instr[31:20]};

        case (opcode)
            OPC_LUI: begin
                dec_legal_c = 1'b1;
                dec_op_c    = ALU_LUI;
                dec_a_c     = '0;
                dec_b_c     = {12'b0, instr[31:12]};
            end
            OPC_IMM: begin
                case (funct3)
                    3'b000: begin
                        dec_legal_c = 1'b1;
                        dec_op_c    = ALU_ADD;
                    end
                    3'b110: begin
                        dec_legal_c = 1'b1;
                        dec_op_c    = ALU_OR;
                    end
                    3'b001: begin
                        dec_legal_c = (funct7 == 7'b0000000);
                        dec_op_c    = ALU_SLL;
                        dec_b_c     = {27'b0, instr[24:20]};
                    end
                    3'b101: begin
                        // funct7=0100000 (SRAI) is not supported here
                        dec_legal_c = (funct7 == 7'b0000000);
                        dec_op_c    = ALU_SRL;
                        dec_b_c     = {27'b0, instr[24:20]};
                    end
                    default: ;
                endcase
            end
            OPC_REG: begin
                if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_legal_c = 1'b1;
                    dec_op_c    = ALU_SUB;
                    dec_b_c     = bus.Rs2_Data_i;
                end
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_wr_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        zero_d    = zero_q;
        illegal_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Instr_Valid_i && ready_q) begin
                    cnt_d   = CNT_RELOAD;
                    ready_d = 1'b0;
                    if (dec_legal_c) begin
                        state_d   = EXEC;
                        op_d      = dec_op_c;
                        a_d       = dec_a_c;
                        b_d       = dec_b_c;
                        rd_addr_d = bus.Instruction_i[11:7];
                    end else begin
                        state_d   = ERR;
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                // Counter reaching zero marks the last cycle operands are held.
                if (cnt_q == '0) begin
                    state_d   = WB;
                    rd_data_d = bus.ALU_Result_i;
                    zero_d    = bus.Zero_i;
                    rd_wr_d   = (rd_addr_q != '0);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB, ERR: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_wr_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_wr_q   <= rd_wr_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.Instr_Ready_o   = ready_q;
    assign bus.ALU_Operation_o = op_q;
    assign bus.A_o             = a_q;
    assign bus.B_o             = b_q;
    assign bus.Rd_Write_o      = rd_wr_q;
    assign bus.Rd_Addr_o       = rd_addr_q;
    assign bus.Rd_Data_o       = rd_data_q;
    assign bus.Zero_o          = zero_q;
    assign bus.Illegal_o       = illegal_q;
endmodule
